// File: rtl/fetch_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl_pkg
// Shared constants, state encoding and helpers for the fetch sequencer.
//   START_POINT      : first fetch address after reset (StartPoint)
//   EXC_VECTOR_ADDR  : exception entry address
//   fetch_state_e    : 3-bit fetch FSM encoding
// -----------------------------------------------------------------------------
package fetch_seq_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ST_W = 3;

    localparam logic [XLEN-1:0] START_POINT     = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_ADDR = 32'hBFC0_0380;

    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_e;

    // Sequential next PC; wraps at 2^32 by construction of the 32-bit add.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

    // States in which the sequencer is actively trying to deliver an instruction.
    function automatic logic is_fetch_active(input fetch_state_e st);
        return (st == ST_REQ) || (st == ST_WAIT) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl
// Fetch sequencer for the five-stage MIPS core. Drives the PC register load
// port, issues instruction-SRAM requests (req/addr_ok/data_ok), buffers a
// fetched word while IF/ID is stalled, applies a pending branch after its delay
// slot and drops in-flight responses after an exception/ERET flush.
//
// Next-PC priority: flush (exception, then ERET) > pending branch > pc+4.
//
// Ports
//   clk, rst              : core clock, synchronous active-high reset
//   cur_pc                : PC register output (address being fetched)
//   pc_in, go_if          : next PC and load enable toward PC register (comb)
//   inst_req, inst_addr   : SRAM request valid / address (comb)
//   inst_addr_ok          : SRAM request accepted
//   inst_data_ok          : SRAM read data valid
//   inst_rdata            : SRAM read data
//   fs_valid, fs_pc,
//   fs_inst               : instruction toward IF/ID (comb)
//   if_allowin            : IF/ID can accept
//   br_taken, br_target   : taken-branch pulse from ID and its target
//   exc_flush             : exception commit pulse
//   eret_flush, epc       : ERET commit pulse and return address
//
// Build option
//   FETCH_PERF_EN : adds perf_fetch_cnt (handoffs) and perf_stall_cnt
//                   (active cycles without a handoff) output ports.
// -----------------------------------------------------------------------------
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = START_POINT,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_ADDR
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [XLEN-1:0] cur_pc,
    output logic [XLEN-1:0] pc_in,
    output logic            go_if,

    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [XLEN-1:0] inst_rdata,

    output logic            fs_valid,
    output logic [XLEN-1:0] fs_pc,
    output logic [XLEN-1:0] fs_inst,
    input  logic            if_allowin,

    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            exc_flush,
    input  logic            eret_flush,
    input  logic [XLEN-1:0] epc
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
`endif
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;

    logic [XLEN-1:0] inst_buf_q;
    logic            buf_load;

    logic            pend_valid_q;
    logic [XLEN-1:0] pend_target_q;

    logic            flush;
    logic            word_avail;
    logic            resp_outstanding;
    logic            handoff;
    logic            pend_hit;
    logic [XLEN-1:0] pend_pc;

    assign flush = exc_flush | eret_flush;

    // A branch reported in the handoff cycle of its delay slot is forwarded so
    // that the delay slot still redirects to the target.
    assign pend_hit = pend_valid_q | (br_taken & ~flush);
    assign pend_pc  = pend_valid_q ? pend_target_q : br_target;

    // The address always follows the PC register; it is only meaningful with inst_req.
    assign inst_addr = cur_pc;
    assign fs_pc     = cur_pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d          = state_q;
        inst_req         = 1'b0;
        word_avail       = 1'b0;
        resp_outstanding = 1'b0;
        buf_load         = 1'b0;
        fs_inst          = inst_rdata;
        fs_valid         = 1'b0;
        handoff          = 1'b0;
        go_if            = 1'b0;
        pc_in            = pend_hit ? pend_pc : seq_pc(cur_pc);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                inst_req         = 1'b1;
                resp_outstanding = inst_addr_ok;
                if (inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                resp_outstanding = ~inst_data_ok;
                if (inst_data_ok) begin
                    word_avail = 1'b1;
                    if (if_allowin) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d  = ST_HOLD;
                        buf_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                word_avail = 1'b1;
                fs_inst    = inst_buf_q;
                if (if_allowin) begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                resp_outstanding = ~inst_data_ok;
                if (inst_data_ok) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fs_valid = word_avail & ~flush;
        handoff  = fs_valid & if_allowin;
        go_if    = handoff;

        // Flush overrides everything; a response still in flight must be dropped.
        if (flush) begin
            go_if    = 1'b1;
            buf_load = 1'b0;
            pc_in    = exc_flush ? EXC_VECTOR : epc;
            state_d  = resp_outstanding ? ST_DISCARD : ST_REQ;
        end

        if (rst) begin
            state_d  = ST_IDLE;
            inst_req = 1'b0;
            fs_valid = 1'b0;
            handoff  = 1'b0;
            go_if    = 1'b0;
            buf_load = 1'b0;
            pc_in    = RESET_PC;
        end
    end

    // Instruction buffer used while IF/ID is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_buf_q <= '0;
        end else if (buf_load) begin
            inst_buf_q <= inst_rdata;
        end
    end

    // Pending branch: set by ID, consumed by the delay-slot handoff, killed by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= RESET_PC;
        end else if (flush || handoff) begin
            pend_valid_q  <= 1'b0;
        end else if (br_taken) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= br_target;
        end
    end

`ifdef FETCH_PERF_EN
    // Handoff and stall counters, free-running with wraparound.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (handoff) begin
                perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
            end
            if (is_fetch_active(state_q) && !handoff) begin
                perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq_ctrl
// Randomised bench for fetch_seq_ctrl. The bench plays the PC register and the
// instruction SRAM and keeps a transaction-level model of the fetch stream:
// which fetch is awaiting acceptance, which response is in flight (and whether
// it is stale), whether a word is parked for IF/ID, and any pending branch.
// -----------------------------------------------------------------------------
module tb_fetch_seq_ctrl;

    localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC  = 32'hBFC0_0380;

    logic        clk;
    logic        rst;
    logic [31:0] cur_pc;
    logic [31:0] pc_in;
    logic        go_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        if_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_flush;
    logic        eret_flush;
    logic [31:0] epc;

    fetch_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cur_pc       (cur_pc),
        .pc_in        (pc_in),
        .go_if        (go_if),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst),
        .if_allowin   (if_allowin),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_flush    (exc_flush),
        .eret_flush   (eret_flush),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model of the fetch stream.
    logic [31:0] m_pc;
    bit          m_boot;      // first cycle after reset, nothing requested yet
    bit          m_want;      // a fetch of m_pc awaits SRAM acceptance
    bit          m_inflight;  // an accepted fetch awaits its data
    bit          m_stale;     // that in-flight response belongs to a flushed path
    bit          m_parked;    // a fetched word waits for IF/ID
    bit          m_pend;
    logic [31:0] m_tgt;

    task automatic model_reset();
        m_pc       = BOOT_PC;
        m_boot     = 1'b1;
        m_want     = 1'b0;
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_parked   = 1'b0;
        m_pend     = 1'b0;
        m_tgt      = '0;
    endtask

    task automatic drive_idle();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        if_allowin   = 1'b1;
        br_taken     = 1'b0;
        br_target    = '0;
        exc_flush    = 1'b0;
        eret_flush   = 1'b0;
        epc          = '0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_eq("rst_go_if",    32'(go_if),    32'd0);
            check_eq("rst_inst_req", 32'(inst_req), 32'd0);
            check_eq("rst_fs_valid", 32'(fs_valid), 32'd0);
            check_eq("rst_pc_in",    pc_in,         BOOT_PC);
            @(negedge clk);
        end
        model_reset();
        cur_pc = m_pc;
        rst    = 1'b0;
    endtask

    // One clock of stimulus, checking and model update. quiet=1 gives the
    // zero-wait, always-ready, event-free memory used right after reset.
    task automatic one_cycle(input bit quiet);
        bit          a_ok, d_ok, allow, exc, eret, flush, avail, fsv, ho, go, br;
        bit          fl_ok;
        int          r;
        logic [31:0] pc_exp, rnd, tgt, ep;

        cur_pc = m_pc;
        rst    = 1'b0;

        a_ok  = m_want     && (quiet || ($urandom_range(0, 2) != 0));
        d_ok  = m_inflight && (quiet || ($urandom_range(0, 2) != 0));
        allow = quiet || ($urandom_range(0, 3) != 0);

        fl_ok = !quiet && !m_boot && !m_stale && !(m_inflight && d_ok);
        r     = $urandom_range(0, 24);
        exc   = fl_ok && (r == 0 || r == 2);
        eret  = fl_ok && (r == 1 || r == 2);
        flush = exc || eret;

        case ($urandom_range(0, 3))
            0:       ep = 32'h8000_0010;
            1:       ep = 32'hFFFF_FFFC;
            2:       ep = 32'hFFFF_FFF8;
            default: begin rnd = $urandom; rnd[1:0] = 2'b00; ep = rnd; end
        endcase

        avail = (m_inflight && !m_stale && d_ok) || m_parked;
        fsv   = avail && !flush;
        ho    = fsv && allow;
        go    = flush || ho;

        br  = !quiet && !m_pend && (flush || !ho) && ($urandom_range(0, 5) == 0);
        rnd = $urandom;
        rnd[1:0] = 2'b00;
        tgt = (rnd[3] ? 32'hBFC0_0100 : rnd);

        inst_addr_ok = a_ok;
        inst_data_ok = d_ok;
        inst_rdata   = (d_ok && !m_stale) ? mem_word(m_pc) : $urandom;
        if_allowin   = allow;
        exc_flush    = exc;
        eret_flush   = eret;
        epc          = ep;
        br_taken     = br;
        br_target    = tgt;

        if (exc)         pc_exp = EXC_PC;
        else if (eret)   pc_exp = ep;
        else if (m_pend) pc_exp = m_tgt;
        else             pc_exp = m_pc + 32'd4;

        #1;
        check_eq("inst_req", 32'(inst_req), 32'(m_want));
        check_eq("go_if",    32'(go_if),    32'(go));
        check_eq("fs_valid", 32'(fs_valid), 32'(fsv));
        if (m_want) check_eq("inst_addr", inst_addr, m_pc);
        if (go)     check_eq("pc_in",     pc_in,     pc_exp);
        if (fsv) begin
            check_eq("fs_inst", fs_inst, mem_word(m_pc));
            check_eq("fs_pc",   fs_pc,   m_pc);
        end

        // Model update for the coming edge.
        if (go) m_pc = pc_exp;
        if (flush || ho) m_pend = 1'b0;
        else if (br) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
        end

        if (m_boot) begin
            m_boot = 1'b0;
            m_want = 1'b1;
        end else if (m_want) begin
            if (a_ok) begin
                m_want     = 1'b0;
                m_inflight = 1'b1;
                m_stale    = flush;
            end
        end else if (m_inflight) begin
            if (d_ok) begin
                m_inflight = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_want  = 1'b1;
                end else if (allow) begin
                    m_want = 1'b1;
                end else begin
                    m_parked = 1'b1;
                end
            end else if (flush) begin
                m_stale = 1'b1;
            end
        end else if (m_parked) begin
            if (flush || allow) begin
                m_parked = 1'b0;
                m_want   = 1'b1;
            end
        end

        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        cur_pc = BOOT_PC;
        drive_idle();
        model_reset();

        do_reset(2);
        for (int i = 0; i < 12; i++) one_cycle(1'b1);
        for (int i = 0; i < 3000; i++) one_cycle(1'b0);

        // Reset in the middle of traffic, then resume.
        do_reset(2);
        for (int i = 0; i < 8; i++) one_cycle(1'b1);
        for (int i = 0; i < 2000; i++) one_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
